// File: rtl/cpu_pkg.sv
// Shared widths, types and constants for the write-back register file and its scoreboard.
package cpu_pkg;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  localparam int CNT_W    = 2;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam reg_addr_t ZERO_REG = {ADDR_W{1'b0}};
  localparam cnt_t      CNT_ZERO = {CNT_W{1'b0}};
  localparam cnt_t      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam cnt_t      CNT_MAX  = {CNT_W{1'b1}};
  localparam word_t     WORD_ZERO = {DATA_W{1'b0}};
endpackage

// File: rtl/wb_pending_scoreboard.sv
// Per-register count of in-flight writers; R0 never accumulates a count.
module wb_pending_scoreboard import cpu_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_en,
  input  logic [ADDR_W-1:0] inc_addr,
  input  logic              dec_en,
  input  logic [ADDR_W-1:0] dec_addr,
  input  logic [ADDR_W-1:0] query_a,
  input  logic [ADDR_W-1:0] query_b,
  input  logic [ADDR_W-1:0] query_i,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b,
  output logic [CNT_W-1:0]  cnt_i,
  output logic              busy
);
  cnt_t cnt_r [NUM_REGS];
  logic inc_s [NUM_REGS];
  logic dec_s [NUM_REGS];
  logic busy_s;

  // Decode per-register increment/decrement events and the aggregate busy flag.
  always_comb begin
    busy_s = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_s[r] = inc_en && (inc_addr == reg_addr_t'(r)) && (r != 0);
      dec_s[r] = dec_en && (dec_addr == reg_addr_t'(r)) && (cnt_r[r] != CNT_ZERO);
      busy_s   = busy_s | (cnt_r[r] != CNT_ZERO);
    end
  end

  // Count state; a simultaneous issue and retire on the same register cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_r[r] <= CNT_ZERO;
      end
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        case ({inc_s[r], dec_s[r]})
          2'b10:   cnt_r[r] <= cnt_r[r] + CNT_ONE;
          2'b01:   cnt_r[r] <= cnt_r[r] - CNT_ONE;
          default: cnt_r[r] <= cnt_r[r];
        endcase
      end
    end
  end

  assign cnt_a = cnt_r[query_a];
  assign cnt_b = cnt_r[query_b];
  assign cnt_i = cnt_r[query_i];
  assign busy  = busy_s;
endmodule

// File: rtl/wb_regfile_scoreboard.sv
// Architectural register file with write-back commit, two read ports and RAW-hazard stall.
// Optional macro WB_BYPASS_EN enables same-cycle write-through and hazard release.
module wb_regfile_scoreboard import cpu_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              use_a,
  input  logic              use_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              stall,
  output logic              busy
);
  word_t regs_r [NUM_REGS];
  cnt_t  cnt_a_s, cnt_b_s, cnt_i_s;
  logic  wb_wr_s, issue_ok_s, ovf_s, haz_a_s, haz_b_s;
  logic  bypass_ok_a_s, bypass_ok_b_s;

  assign wb_wr_s    = wb_valid && wb_we && (wb_addr != ZERO_REG);
  assign issue_ok_s = issue_en && !stall;

  wb_pending_scoreboard u_sb (
    .clk      (clk),
    .reset    (reset),
    .inc_en   (issue_ok_s),
    .inc_addr (issue_dest),
    .dec_en   (wb_valid),
    .dec_addr (wb_addr),
    .query_a  (rd_addr_a),
    .query_b  (rd_addr_b),
    .query_i  (issue_dest),
    .cnt_a    (cnt_a_s),
    .cnt_b    (cnt_b_s),
    .cnt_i    (cnt_i_s),
    .busy     (busy)
  );

  // Register array commit; R0 is never written so it stays zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_r[r] <= WORD_ZERO;
      end
    end else if (wb_wr_s) begin
      regs_r[wb_addr] <= wb_data;
    end
  end

  // Read muxes, optional write-through, and the stall decision.
  always_comb begin
    rd_data_a = (rd_addr_a == ZERO_REG) ? WORD_ZERO : regs_r[rd_addr_a];
    rd_data_b = (rd_addr_b == ZERO_REG) ? WORD_ZERO : regs_r[rd_addr_b];
`ifdef WB_BYPASS_EN
    if (wb_wr_s && (wb_addr == rd_addr_a)) begin
      rd_data_a = wb_data;
    end else begin
      rd_data_a = rd_data_a;
    end
    if (wb_wr_s && (wb_addr == rd_addr_b)) begin
      rd_data_b = wb_data;
    end else begin
      rd_data_b = rd_data_b;
    end
    bypass_ok_a_s = wb_wr_s && (wb_addr == rd_addr_a) && (cnt_a_s == CNT_ONE);
    bypass_ok_b_s = wb_wr_s && (wb_addr == rd_addr_b) && (cnt_b_s == CNT_ONE);
`else
    bypass_ok_a_s = 1'b0;
    bypass_ok_b_s = 1'b0;
`endif
    haz_a_s = use_a && (rd_addr_a != ZERO_REG) && (cnt_a_s != CNT_ZERO) && !bypass_ok_a_s;
    haz_b_s = use_b && (rd_addr_b != ZERO_REG) && (cnt_b_s != CNT_ZERO) && !bypass_ok_b_s;
    // Overflow deliberately ignores a same-cycle retire of issue_dest.
    ovf_s   = issue_en && (issue_dest != ZERO_REG) && (cnt_i_s == CNT_MAX);
    stall   = haz_a_s || haz_b_s || ovf_s;
  end
endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed bench for wb_regfile_scoreboard; expectations follow WB_BYPASS_EN when defined.
module tb_wb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        reset, wb_valid, wb_we, use_a, use_b, issue_en, stall, busy;
  logic [3:0]  wb_addr, rd_addr_a, rd_addr_b, issue_dest;
  logic [31:0] wb_data, rd_data_a, rd_data_b;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  wb_regfile_scoreboard dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .use_a(use_a),
    .use_b(use_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .issue_en(issue_en),
    .issue_dest(issue_dest), .stall(stall), .busy(busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; wb_valid = 1'b0; wb_we = 1'b0; wb_addr = 4'd0; wb_data = 32'd0;
    rd_addr_a = 4'd0; rd_addr_b = 4'd0; use_a = 1'b0; use_b = 1'b0;
    issue_en = 1'b0; issue_dest = 4'd0;
    step(); step();
    reset = 1'b0;

    // Reset state
    rd_addr_a = 4'd5; use_a = 1'b1; settle();
    check_val("rst_rd_a", rd_data_a, 32'd0);
    check_val("rst_stall", {31'd0, stall}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);

    // RAW hazard on R3
    use_a = 1'b0; issue_en = 1'b1; issue_dest = 4'd3; settle();
    check_val("iss3_stall", {31'd0, stall}, 32'd0);
    step();
    issue_en = 1'b0; rd_addr_a = 4'd3; use_a = 1'b1; settle();
    check_val("raw3_stall", {31'd0, stall}, 32'd1);
    check_val("raw3_busy", {31'd0, busy}, 32'd1);
    wb_valid = 1'b1; wb_we = 1'b1; wb_addr = 4'd3; wb_data = 32'h0000_00A5; settle();
`ifdef WB_BYPASS_EN
    check_val("wb3_rd_a", rd_data_a, 32'h0000_00A5);
    check_val("wb3_stall", {31'd0, stall}, 32'd0);
`else
    check_val("wb3_rd_a", rd_data_a, 32'd0);
    check_val("wb3_stall", {31'd0, stall}, 32'd1);
`endif
    step();
    wb_valid = 1'b0; wb_we = 1'b0; settle();
    check_val("post3_stall", {31'd0, stall}, 32'd0);
    check_val("post3_rd_a", rd_data_a, 32'h0000_00A5);
    check_val("post3_busy", {31'd0, busy}, 32'd0);

    // R0 is immune to writes and issues
    wb_valid = 1'b1; wb_we = 1'b1; wb_addr = 4'd0; wb_data = 32'hFFFF_FFFF;
    issue_en = 1'b1; issue_dest = 4'd0; rd_addr_a = 4'd0; settle();
    check_val("r0_rd_same", rd_data_a, 32'd0);
    check_val("r0_stall_same", {31'd0, stall}, 32'd0);
    step();
    wb_valid = 1'b0; wb_we = 1'b0; issue_en = 1'b0; settle();
    check_val("r0_rd_next", rd_data_a, 32'd0);
    check_val("r0_busy", {31'd0, busy}, 32'd0);
    check_val("r0_stall_next", {31'd0, stall}, 32'd0);

    // Counter saturation on R7
    use_a = 1'b0; issue_en = 1'b1; issue_dest = 4'd7;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_val($sformatf("iss7_%0d_stall", i), {31'd0, stall}, 32'd0);
      step();
    end
    settle();
    check_val("ovf7_stall", {31'd0, stall}, 32'd1);
    step();
    issue_en = 1'b0; wb_valid = 1'b1; wb_we = 1'b0; wb_addr = 4'd7;
    step();
    wb_valid = 1'b0; issue_en = 1'b1; settle();
    check_val("refill7_stall", {31'd0, stall}, 32'd0);
    step();
    settle();
    check_val("ovf7_again", {31'd0, stall}, 32'd1);
    issue_en = 1'b0; wb_valid = 1'b1; wb_addr = 4'd7;
    step(); step(); step();
    wb_valid = 1'b0; settle();
    check_val("drain7_busy", {31'd0, busy}, 32'd0);

    // Same-cycle issue and retire on R2 leaves the count unchanged
    issue_en = 1'b1; issue_dest = 4'd2;
    step();
    wb_valid = 1'b1; wb_we = 1'b1; wb_addr = 4'd2; wb_data = 32'h0000_0055; settle();
    check_val("r2_both_stall", {31'd0, stall}, 32'd0);
    step();
    issue_en = 1'b0; wb_valid = 1'b0; wb_we = 1'b0;
    rd_addr_b = 4'd2; use_b = 1'b1; settle();
    check_val("r2_still_stall", {31'd0, stall}, 32'd1);
    check_val("r2_busy", {31'd0, busy}, 32'd1);
    check_val("r2_rd_b", rd_data_b, 32'h0000_0055);
    wb_valid = 1'b1; wb_addr = 4'd2;
    step();
    wb_valid = 1'b0; settle();
    check_val("r2_release", {31'd0, stall}, 32'd0);
    check_val("r2_idle", {31'd0, busy}, 32'd0);

    // Reset mid-flight discards counts; stray retire does not underflow
    use_b = 1'b0; issue_en = 1'b1; issue_dest = 4'd9;
    step(); step();
    issue_en = 1'b0; settle();
    check_val("r9_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0; rd_addr_a = 4'd9; use_a = 1'b1; rd_addr_b = 4'd2; settle();
    check_val("r9_rst_busy", {31'd0, busy}, 32'd0);
    check_val("r9_rst_stall", {31'd0, stall}, 32'd0);
    check_val("r9_rst_rd_b", rd_data_b, 32'd0);
    wb_valid = 1'b1; wb_we = 1'b0; wb_addr = 4'd9;
    step();
    wb_valid = 1'b0; settle();
    check_val("r9_stray_busy", {31'd0, busy}, 32'd0);
    check_val("r9_stray_stall", {31'd0, stall}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
